puf_crp_ctrl: RTL and testbench
===============================

Name: puf_crp_ctrl

Overview:
- Challenge-response controller that drives the XOR PUF core (xor_top) and collects its responses.
- Generates challenges with an internal Galois LFSR and presents each one on puf_sel.
- For each challenge: precharges and launches the PUF input, synchronises and samples the response, and majority-votes over repeated evaluations.
- Packs the voted bits into a response word and hands it off with a valid/ready handshake.

Parameters:
- N, 128: challenge width; matches the xor_top stage count.
- TAPS, 128'hE1000000000000000000000000000000: Galois feedback mask, N bits wide.
- SETTLE, 4: cycles the PUF input is held low (precharge) and high (launch) before sampling; must be >= 1.
- VOTES, 5: evaluations per challenge; must be odd and >= 1.
- RESP_W, 16: response bits per output word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- seed_load  input  1  in IDLE, load seed into the LFSR.
- seed  input  N  LFSR seed value.
- start  input  1  in IDLE, begin collecting one response word.
- puf_in  output  1  launch signal to xor_top "in".
- puf_sel  output  N  challenge to xor_top "sel"; equals the LFSR state.
- puf_out  input  1  response from xor_top "out"; treated as asynchronous.
- busy  output  1  high whenever state != IDLE.
- resp_word  output  RESP_W  collected response word.
- resp_valid  output  1  resp_word is valid.
- resp_ready  input  1  consumer accepts resp_word.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, LFSR=1, puf_in=0, busy=0, resp_valid=0, resp_word=0.
  - All counters=0; both synchroniser flops=0.
  - Reset mid-run aborts the run and discards any partial word.
- LFSR step: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
  - A seed of 0 is loaded as 1, so the all-zero lock-up state is never reached.
- puf_out passes through a 2-flop synchroniser; puf_out_s is the second flop output.
- IDLE:
  - puf_in=0.
  - seed_load=1 loads the LFSR.
  - start=1 goes to PRECHARGE; bit_cnt=0, vote_cnt=0, ones=0.
  - If seed_load and start are high together, the seed is loaded and becomes the first challenge.
- Outside IDLE, start and seed_load are ignored.
- PRECHARGE:
  - puf_in=0 for SETTLE cycles, then go to LAUNCH.
- LAUNCH:
  - puf_in=1 for SETTLE+2 cycles (the +2 covers synchroniser latency), then go to SAMPLE.
- SAMPLE (1 cycle):
  - puf_in=1; ones += puf_out_s; vote_cnt += 1.
  - If vote_cnt (after increment) < VOTES, go to PRECHARGE with the same challenge.
  - Otherwise go to NEXT.
- NEXT (1 cycle):
  - puf_in=0.
  - Voted bit = (ones > VOTES/2), using integer division.
  - Shift register: sreg = {bit, sreg[RESP_W-1:1]}, so the first challenge lands in resp_word[0].
  - Step the LFSR; bit_cnt += 1; vote_cnt=0; ones=0.
  - If bit_cnt == RESP_W, go to OUTPUT and load resp_word=sreg. Otherwise go to PRECHARGE.
- OUTPUT:
  - resp_valid=1; resp_word is held stable.
  - When resp_valid && resp_ready: next cycle resp_valid=0 and state=IDLE.
  - resp_ready may be high before resp_valid rises; the handshake then completes in the first OUTPUT cycle.
- The LFSR keeps its state across words. Consecutive words continue the sequence unless it is reseeded.
- Latency:
  - One vote takes 2*SETTLE+3 cycles; one bit takes VOTES*(2*SETTLE+3)+1 cycles.
  - resp_valid rises exactly 1 + RESP_W*(VOTES*(2*SETTLE+3)+1) cycles after the start edge.
  - Defaults give 897 cycles.
- puf_sel is stable from entry into PRECHARGE until the NEXT edge, so the challenge never changes while puf_in=1.

Test Plan:
- Bench parameters: N=8, TAPS=8'hB8, SETTLE=2, VOTES=3, RESP_W=4.
- Scenario 1: seed_load with seed=8'h01, then start, puf_out tied 1 -> puf_sel sequence 01, B8, 5C, 2E; resp_word=4'hF; resp_valid exactly 1+4*(3*7+1)=89 cycles after start.
- Scenario 2: seed=8'h00 loaded -> puf_sel=8'h01; puf_out tied 0 -> resp_word=4'h0.
- Scenario 3: puf_out scripted per vote as (1,0,1) for bit 0, (0,0,1) for bit 1, (1,1,0) for bit 2, (0,1,0) for bit 3 -> resp_word=4'b0101.
- Scenario 4: resp_ready=0 for 10 cycles after resp_valid -> resp_word and resp_valid held stable; start pulses during busy are ignored; resp_ready=1 -> IDLE next cycle; busy=0.
- Scenario 5: reset=0 asynchronously mid-LAUNCH -> puf_in, busy and resp_valid=0 immediately; after release, puf_sel=8'h01 and state is IDLE.
- Scenario 6: check puf_sel stays constant throughout every puf_in=1 window (assertion), and that two back-to-back words continue the LFSR sequence (second word starts at the 5th LFSR state, 8'h17).

Source files
------------

// File: rtl/puf_crp_ctrl.sv
// Challenge-response controller for the XOR PUF core.
// LFSR challenges, precharge/launch timing, majority vote, word hand-off.
module puf_crp_ctrl #(
  parameter int            N      = 128,
  parameter logic [N-1:0]  TAPS   = 128'hE1000000000000000000000000000000,
  parameter int            SETTLE = 4,
  parameter int            VOTES  = 5,
  parameter int            RESP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [N-1:0]      seed,
  input  logic              start,
  output logic              puf_in,
  output logic [N-1:0]      puf_sel,
  input  logic              puf_out,
  output logic              busy,
  output logic [RESP_W-1:0] resp_word,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int CW = $clog2(SETTLE + 2) + 1;
  localparam int VW = $clog2(VOTES + 1) + 1;
  localparam int BW = $clog2(RESP_W + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    LAUNCH,
    SAMPLE,
    NEXT,
    OUTPUT
  } state_t;

  state_t            state;
  logic [N-1:0]      lfsr;
  logic [CW-1:0]     cnt;
  logic [VW-1:0]     vote_cnt;
  logic [VW-1:0]     ones;
  logic [BW-1:0]     bit_cnt;
  logic [RESP_W-1:0] sreg;
  logic              sync1;
  logic              puf_out_s;

  logic [N-1:0]      lfsr_next;
  logic              voted;
  logic [RESP_W-1:0] sreg_next;

  assign puf_sel   = lfsr;
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign voted     = ones > VW'(VOTES / 2);
  assign sreg_next = {voted, sreg[RESP_W-1:1]};

  // Two-flop synchroniser for the asynchronous PUF response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      puf_out_s <= 1'b0;
    end else begin
      sync1     <= puf_out;
      puf_out_s <= sync1;
    end
  end

  // Main sequencer; outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= N'(1);
      cnt        <= '0;
      vote_cnt   <= '0;
      ones       <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      puf_in     <= 1'b0;
      busy       <= 1'b0;
      resp_word  <= '0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          puf_in <= 1'b0;
          if (seed_load)
            lfsr <= (seed == '0) ? N'(1) : seed;
          if (start) begin
            state    <= PRECHARGE;
            busy     <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            vote_cnt <= '0;
            ones     <= '0;
          end
        end
        PRECHARGE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            cnt    <= '0;
            state  <= LAUNCH;
            puf_in <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LAUNCH: begin
          if (cnt == CW'(SETTLE + 1)) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SAMPLE: begin
          ones     <= ones + VW'(puf_out_s);
          vote_cnt <= vote_cnt + VW'(1);
          puf_in   <= 1'b0;
          if (vote_cnt + VW'(1) < VW'(VOTES))
            state <= PRECHARGE;
          else
            state <= NEXT;
        end
        NEXT: begin
          sreg     <= sreg_next;
          lfsr     <= lfsr_next;
          bit_cnt  <= bit_cnt + BW'(1);
          vote_cnt <= '0;
          ones     <= '0;
          if (bit_cnt + BW'(1) == BW'(RESP_W))
            state <= OUTPUT;
          else
            state <= PRECHARGE;
        end
        OUTPUT: begin
          // First OUTPUT cycle latches the completed shift register.
          if (!resp_valid) begin
            resp_word  <= sreg;
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_crp_ctrl.sv
// Self-checking bench for puf_crp_ctrl.
// Table vectors, scripted corner cases and random words vs a reference model.
module tb_puf_crp_ctrl;

  localparam int         N      = 8;
  localparam logic [7:0] TAPS   = 8'hB8;
  localparam int         SETTLE = 2;
  localparam int         VOTES  = 3;
  localparam int         RESP_W = 4;
  localparam int         LAT    = 1 + RESP_W * (VOTES * (2 * SETTLE + 3) + 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       seed_load;
  logic [7:0] seed;
  logic       start;
  logic       puf_in;
  logic [7:0] puf_sel;
  logic       puf_out;
  logic       busy;
  logic [3:0] resp_word;
  logic       resp_valid;
  logic       resp_ready;

  puf_crp_ctrl #(
    .N(N), .TAPS(TAPS), .SETTLE(SETTLE),
    .VOTES(VOTES), .RESP_W(RESP_W)
  ) dut (
    .clk(clk), .reset(reset),
    .seed_load(seed_load), .seed(seed),
    .start(start), .puf_in(puf_in),
    .puf_sel(puf_sel), .puf_out(puf_out),
    .busy(busy), .resp_word(resp_word),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: LFSR rule in plain arithmetic.
  function automatic logic [7:0] m_step(input logic [7:0] x);
    logic [7:0] r;
    r = x / 2;
    if (x % 2 == 1) r = r ^ TAPS;
    return r;
  endfunction

  function automatic logic [7:0] m_stepn(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = m_step(r);
    return r;
  endfunction

  // Reference model: majority of three votes per bit, bit 0 first.
  function automatic logic [3:0] m_word(input logic [11:0] pat);
    logic [3:0] w;
    for (int b = 0; b < RESP_W; b++) begin
      int n;
      n = int'(pat[3*b]) + int'(pat[3*b+1]) + int'(pat[3*b+2]);
      w[b] = (n * 2 > VOTES);
    end
    return w;
  endfunction

  logic [11:0] cur_pat = '0;
  int          vidx = 0;
  logic [7:0]  sel_log[$];
  logic        prev_in = 1'b0;
  logic [7:0]  prev_sel = '0;

  // PUF stand-in: one scripted vote value per launch, challenge logging,
  // and challenge stability while the launch is high.
  always @(negedge clk) begin
    if (puf_in && !prev_in) begin
      if (vidx < 12) puf_out = cur_pat[vidx];
      vidx++;
      sel_log.push_back(puf_sel);
    end
    if (puf_in && prev_in) chk("sel_stable", 32'(puf_sel), 32'(prev_sel));
    prev_in  = puf_in;
    prev_sel = puf_sel;
  end

  typedef struct {
    logic        do_seed;
    logic [7:0]  seed;
    logic [11:0] pat;
    logic [3:0]  exp_word;
    logic [7:0]  exp_sel0;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] m_lfsr;

  task automatic run_word(input logic do_seed, input logic [7:0] sd,
                          input logic [11:0] pat, input logic [3:0] exp_w,
                          input logic [7:0] exp_s0, input logic early);
    int cyc;
    cur_pat = pat;
    vidx = 0;
    sel_log.delete();
    @(negedge clk);
    seed_load  = do_seed;
    seed       = sd;
    start      = 1'b1;
    resp_ready = early;
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    cyc = 0;
    while (!resp_valid && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency", cyc, LAT);
    chk("resp_word", 32'(resp_word), 32'(exp_w));
    chk("vote_count", sel_log.size(), 12);
    for (int b = 0; b < RESP_W; b++)
      if (sel_log.size() > 3 * b)
        chk("puf_sel", 32'(sel_log[3*b]), 32'(m_stepn(exp_s0, b)));
    if (early) begin
      @(negedge clk);
      chk("valid_drop", 32'(resp_valid), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b0;
    seed_load  = 1'b0;
    seed       = '0;
    start      = 1'b0;
    puf_out    = 1'b0;
    resp_ready = 1'b0;

    vecs[0] = '{1'b1, 8'h01, 12'hFFF, 4'hF, 8'h01};
    vecs[1] = '{1'b1, 8'h00, 12'h000, 4'h0, 8'h01};
    vecs[2] = '{1'b1, 8'h01, 12'h4E5, 4'h5, 8'h01};
    vecs[3] = '{1'b0, 8'h00, 12'h0F0, 4'h6, 8'h17};

    repeat (3) @(negedge clk);
    chk("rst_puf_in", 32'(puf_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_word", 32'(resp_word), 32'd0);
    chk("rst_sel", 32'(puf_sel), 32'h01);
    reset = 1'b1;

    for (int i = 0; i < 4; i++)
      run_word(vecs[i].do_seed, vecs[i].seed, vecs[i].pat,
               vecs[i].exp_word, vecs[i].exp_sel0, 1'b1);
    m_lfsr = m_stepn(8'h17, RESP_W);

    begin
      logic [11:0] p;
      logic [3:0]  w;
      p = 12'($urandom);
      w = m_word(p);
      run_word(1'b0, 8'h00, p, w, m_lfsr, 1'b0);
      m_lfsr = m_stepn(m_lfsr, RESP_W);
      for (int k = 0; k < 10; k++) begin
        start = 1'b1;
        @(negedge clk);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_word", 32'(resp_word), 32'(w));
        chk("hold_busy", 32'(busy), 32'd1);
      end
      start      = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("late_valid", 32'(resp_valid), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("stay_idle", 32'(busy), 32'd0);
    end

    begin
      int guard;
      cur_pat = 12'hFFF;
      vidx = 0;
      @(negedge clk);
      seed_load = 1'b1;
      seed      = 8'h55;
      start     = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      start     = 1'b0;
      guard = 0;
      while (!puf_in && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("reach_launch", 32'(puf_in), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_puf_in", 32'(puf_in), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("arst_sel", 32'(puf_sel), 32'h01);
      chk("arst_idle", 32'(busy), 32'd0);
      m_lfsr = 8'h01;
    end

    for (int r = 0; r < 4; r++) begin
      logic        ds;
      logic [7:0]  sd;
      logic [11:0] p;
      ds = 1'($urandom_range(0, 1));
      sd = 8'($urandom_range(0, 255));
      p  = 12'($urandom);
      if (ds) m_lfsr = (sd == 8'h00) ? 8'h01 : sd;
      run_word(ds, sd, p, m_word(p), m_lfsr, 1'b1);
      m_lfsr = m_stepn(m_lfsr, RESP_W);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
